// File: rtl/pulse_train_gen_pkg.sv
// pulse_train_pkg: shared state encoding, request record and length mapping for the pulse train generator
package pulse_train_pkg;
    localparam int PTG_CNT_W = 8;
    localparam int PTG_MIN_LEN = 1;
    typedef enum logic [1:0] {IDLE, HIGH, LOW} ptg_state_e;
    typedef struct packed {
        logic [PTG_CNT_W-1:0] high;
        logic [PTG_CNT_W-1:0] low;
        logic [PTG_CNT_W-1:0] num;
    } ptg_cfg_t;
    // a zero-length phase would never be visible on the line, so it is stretched to one cycle
    function automatic logic [PTG_CNT_W-1:0] ptg_len(input logic [PTG_CNT_W-1:0] len);
        return (len == '0) ? PTG_CNT_W'(PTG_MIN_LEN) : len;
    endfunction
endpackage

// File: rtl/pulse_train_gen_if.sv
// pulse_train_gen_if: request handshake, train settings and waveform/status lines of the pulse train generator
interface pulse_train_gen_if
    import pulse_train_pkg::*;
#(
    parameter int CNT_W = PTG_CNT_W
);
    logic             req_valid;
    logic             req_ready;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W-1:0] num_pulses;
    logic             abort;
    logic             pulse;
    logic             busy;
    logic             done;
    modport master (
        output req_valid, high_len, low_len, num_pulses, abort,
        input  req_ready, pulse, busy, done
    );
    modport slave (
        input  req_valid, high_len, low_len, num_pulses, abort,
        output req_ready, pulse, busy, done
    );
endinterface

// File: rtl/ptg_phase_counter.sv
// ptg_phase_counter: loadable down-counter that times one high or low phase and flags its last cycle
module ptg_phase_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);
    assign zero = (count == '0);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && !zero)
            count <= count - 1'b1;
    end
endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits N pulses of programmable high/low width on one registered line per accepted request
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int CNT_W = PTG_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    pulse_train_gen_if.slave    bus
);
    ptg_state_e       state, state_n;
    ptg_cfg_t         req;
    logic [CNT_W-1:0] high_q, low_q, high_n, low_n;
    logic [CNT_W-1:0] pcnt, pcnt_n, load_val, phase;
    logic             accept, load, dec, clr, zero;
    logic             pulse_q, pulse_n, done_q, done_n;

    assign req    = '{high: ptg_len(bus.high_len), low: ptg_len(bus.low_len), num: bus.num_pulses};
    assign accept = bus.req_valid && (state == IDLE);

    ptg_phase_counter #(.CNT_W(CNT_W)) u_phase (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .load     (load),
        .dec      (dec),
        .load_val (load_val),
        .count    (phase),
        .zero     (zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            high_q  <= '0;
            low_q   <= '0;
            pcnt    <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            high_q  <= high_n;
            low_q   <= low_n;
            pcnt    <= pcnt_n;
            pulse_q <= pulse_n;
            done_q  <= done_n;
        end
    end

    // pulse counter drops at each HIGH->LOW, so reaching 0 at the end of LOW means the last pulse is out
    always_comb begin
        state_n  = state;
        high_n   = high_q;
        low_n    = low_q;
        pcnt_n   = pcnt;
        load     = 1'b0;
        dec      = 1'b0;
        clr      = 1'b0;
        load_val = '0;
        pulse_n  = 1'b0;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    high_n = req.high;
                    low_n  = req.low;
                    if (req.num != '0) begin
                        state_n  = HIGH;
                        load     = 1'b1;
                        load_val = req.high - 1'b1;
                        pcnt_n   = req.num;
                        pulse_n  = 1'b1;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (bus.abort) begin
                    state_n = IDLE;
                    clr     = 1'b1;
                    pcnt_n  = '0;
                end else if (zero) begin
                    state_n  = LOW;
                    load     = 1'b1;
                    load_val = low_q - 1'b1;
                    pcnt_n   = pcnt - 1'b1;
                end else begin
                    dec     = 1'b1;
                    pulse_n = 1'b1;
                end
            end
            LOW: begin
                if (bus.abort) begin
                    state_n = IDLE;
                    clr     = 1'b1;
                    pcnt_n  = '0;
                end else if (zero && pcnt == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (zero) begin
                    state_n  = HIGH;
                    load     = 1'b1;
                    load_val = high_q - 1'b1;
                    pulse_n  = 1'b1;
                end else begin
                    dec = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.pulse     = pulse_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state != IDLE);
    assign bus.req_ready = (state == IDLE);
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: scoreboard bench; each accepted request queues its full expected per-cycle waveform
module tb_pulse_train_gen;
    import pulse_train_pkg::*;
    localparam int W = PTG_CNT_W;
    typedef struct packed {
        logic pulse;
        logic busy;
        logic done;
        logic ready;
    } exp_t;
    localparam exp_t IDLE_E = exp_t'(4'b0001);
    localparam exp_t HI_E   = exp_t'(4'b1100);
    localparam exp_t LO_E   = exp_t'(4'b0100);
    localparam exp_t DONE_E = exp_t'(4'b0011);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pulse_train_gen_if #(.CNT_W(W)) bus ();
    pulse_train_gen #(.CNT_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t q[$];
    exp_t cur = IDLE_E;
    int   checks = 0;
    int   errors = 0;
    int   t = 0;
    int   done_at = 0;
    int   rises = 0;
    int   falls = 0;
    logic prev_pulse = 1'b0;

    task automatic push(input logic [W-1:0] h, input logic [W-1:0] l, input logic [W-1:0] n);
        int hh = (h == 0) ? 1 : int'(h);
        int ll = (l == 0) ? 1 : int'(l);
        for (int p = 0; p < int'(n); p++) begin
            repeat (hh) q.push_back(HI_E);
            repeat (ll) q.push_back(LO_E);
        end
        q.push_back(DONE_E);
    endtask

    task automatic compare();
        checks++;
        if (bus.pulse !== cur.pulse) begin
            errors++;
            $display("FAIL pulse t=%0d got %b exp %b", t, bus.pulse, cur.pulse);
        end
        checks++;
        if (bus.busy !== cur.busy) begin
            errors++;
            $display("FAIL busy t=%0d got %b exp %b", t, bus.busy, cur.busy);
        end
        checks++;
        if (bus.done !== cur.done) begin
            errors++;
            $display("FAIL done t=%0d got %b exp %b", t, bus.done, cur.done);
        end
        checks++;
        if (bus.req_ready !== cur.ready) begin
            errors++;
            $display("FAIL ready t=%0d got %b exp %b", t, bus.req_ready, cur.ready);
        end
        checks++;
        if (bus.busy === 1'b0 && bus.pulse !== 1'b0) begin
            errors++;
            $display("FAIL idle_pulse t=%0d got %b exp 0", t, bus.pulse);
        end
    endtask

    task automatic step();
        logic v = bus.req_valid;
        logic a = bus.abort;
        logic [W-1:0] h = bus.high_len;
        logic [W-1:0] l = bus.low_len;
        logic [W-1:0] n = bus.num_pulses;
        @(posedge clk);
        if (cur.ready && v)
            push(h, l, n);
        else if (!cur.ready && a)
            q.delete();
        if (q.size() > 0)
            cur = q.pop_front();
        else
            cur = IDLE_E;
        t++;
        #1;
        compare();
        if (bus.pulse === 1'b1 && !prev_pulse) rises++;
        if (bus.pulse === 1'b0 && prev_pulse) falls++;
        prev_pulse = bus.pulse;
        if (bus.done === 1'b1) done_at = t;
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) step();
    endtask

    task automatic run_to_done(input int max);
        for (int k = 0; k < max; k++) begin
            step();
            if (bus.done === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout t=%0d got no done exp done within %0d", t, max);
    endtask

    task automatic send(input logic [W-1:0] h, input logic [W-1:0] l, input logic [W-1:0] n);
        bus.high_len   = h;
        bus.low_len    = l;
        bus.num_pulses = n;
        bus.req_valid  = 1'b1;
        step();
        bus.req_valid  = 1'b0;
        bus.high_len   = $urandom_range(255, 0);
        bus.low_len    = $urandom_range(255, 0);
        bus.num_pulses = $urandom_range(255, 0);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        cur = IDLE_E;
        compare();
        reset = 1'b0;
        run(2);
    endtask

    task automatic test_basic();
        t = 0;
        done_at = 0;
        rises = 0;
        falls = 0;
        send(2, 3, 2);
        run_to_done(20);
        check_int("basic_done_cycle", done_at, 11);
        check_int("basic_rises", rises, 2);
        check_int("basic_falls", falls, 2);
    endtask

    task automatic test_back_to_back();
        done_at = 0;
        send(1, 1, 1);
        checks++;
        if (bus.pulse !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start t=%0d got %b exp 1", t, bus.pulse);
        end
        run_to_done(10);
        check_int("b2b_done_cycle", done_at, 14);
        run(2);
    endtask

    task automatic test_empty();
        t = 0;
        done_at = 0;
        send(5, 5, 0);
        check_int("empty_done_cycle", done_at, 1);
        run(4);
        check_int("empty_done_once", done_at, 1);
    endtask

    task automatic test_zero_len();
        t = 0;
        done_at = 0;
        send(0, 0, 3);
        run_to_done(20);
        check_int("zero_len_done_cycle", done_at, 7);
        run(2);
    endtask

    task automatic test_abort();
        t = 0;
        done_at = 0;
        send(4, 4, 3);
        while (t < 10) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++;
        if (bus.pulse !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_stop t=%0d got pulse %b ready %b exp pulse 0 ready 1", t, bus.pulse, bus.req_ready);
        end
        run(30);
        check_int("abort_no_done", done_at, 0);
    endtask

    task automatic test_abort_edges();
        t = 0;
        done_at = 0;
        send(1, 2, 1);
        while (t < 3) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        run(3);
        check_int("abort_last_low_no_done", done_at, 0);
        t = 0;
        bus.abort = 1'b1;
        send(1, 1, 1);
        bus.abort = 1'b0;
        run_to_done(10);
        check_int("abort_idle_accept_done", done_at, 3);
        run(2);
    endtask

    task automatic test_reset_mid();
        t = 0;
        done_at = 0;
        send(2, 5, 2);
        while (t < 4) step();
        #2 reset = 1'b1;
        q.delete();
        cur = IDLE_E;
        #1;
        compare();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        prev_pulse = 1'b0;
        run(5);
        check_int("reset_no_done", done_at, 0);
        t = 0;
        send(1, 1, 1);
        run_to_done(10);
        check_int("reset_new_req_done", done_at, 3);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.abort      = 1'b0;
        bus.high_len   = '0;
        bus.low_len    = '0;
        bus.num_pulses = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_empty();
        test_zero_len();
        test_abort();
        test_abort_edges();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish by 200000");
        $fatal(1, "watchdog");
    end
endmodule
